// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage scalar ALU with multi-cycle 4x4 int8 outer-product accumulator
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int ACC_W = 32,
  parameter int TILE  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  illegal,
  input  logic                  acc_clr,
  input  logic [1:0]            acc_rd_row,
  output logic [TILE*ACC_W-1:0] acc_rd_data
);

  // Operation codes shared with the decode-side ALU control
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_NOTEQ = 4'd10;
  localparam logic [3:0] OP_SGE   = 4'd11;
  localparam logic [3:0] OP_SGEU  = 4'd12;
  localparam logic [3:0] OP_JUMP  = 4'd13;
  localparam logic [3:0] OP_MOPA  = 4'd14;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  a_lat_q, a_lat_d;
  logic [XLEN-1:0]  b_lat_q, b_lat_d;
  logic [ACC_W-1:0] acc_q [TILE][TILE];
  logic [ACC_W-1:0] acc_d [TILE][TILE];

  logic             accept;
  logic [XLEN-1:0]  scalar_res;
  logic             scalar_ill;
  logic [4:0]       shamt;
  logic signed [7:0]  a_lane, b_lane;
  logic signed [15:0] prod;

  assign in_ready  = (state_q == S_IDLE) && !acc_clr && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign shamt     = op_b[4:0];

  // Single-cycle scalar datapath; unknown codes produce 0 and flag illegal
  always_comb begin
    scalar_res = '0;
    scalar_ill = 1'b0;
    case (alu_ctrl)
      OP_ADD:   scalar_res = op_a + op_b;
      OP_SUB:   scalar_res = op_a - op_b;
      OP_SLL:   scalar_res = op_a << shamt;
      OP_SLT:   scalar_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  scalar_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:   scalar_res = op_a ^ op_b;
      OP_SRL:   scalar_res = op_a >> shamt;
      OP_SRA:   scalar_res = XLEN'($signed(op_a) >>> shamt);
      OP_OR:    scalar_res = op_a | op_b;
      OP_AND:   scalar_res = op_a & op_b;
      OP_NOTEQ: scalar_res = {{(XLEN-1){1'b0}}, op_a != op_b};
      OP_SGE:   scalar_res = {{(XLEN-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
      OP_SGEU:  scalar_res = {{(XLEN-1){1'b0}}, op_a >= op_b};
      OP_JUMP:  scalar_res = op_a + XLEN'(4);
      default:  scalar_ill = 1'b1;
    endcase
  end

  // Next-state: handshake/FSM control plus accumulator clear and row update
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    a_lat_d     = a_lat_q;
    b_lat_d     = b_lat_q;
    acc_d       = acc_q;
    a_lane      = '0;
    b_lane      = '0;
    prod        = '0;

    // Clear first so a row being updated this edge starts from zero
    if (acc_clr) begin
      for (int r = 0; r < TILE; r++) begin
        for (int j = 0; j < TILE; j++) begin
          acc_d[r][j] = '0;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (alu_ctrl == OP_MOPA) begin
            a_lat_d = op_a;
            b_lat_d = op_b;
            row_d   = '0;
            state_d = S_BUSY;
          end else begin
            out_valid_d = 1'b1;
            result_d    = scalar_res;
            zero_d      = (scalar_res == '0);
            illegal_d   = scalar_ill;
          end
        end
      end
      S_BUSY: begin
        a_lane = a_lat_q[8*row_q +: 8];
        for (int j = 0; j < TILE; j++) begin
          b_lane = b_lat_q[8*j +: 8];
          prod   = a_lane * b_lane;
          acc_d[row_q][j] = acc_d[row_q][j] + {{(ACC_W-16){prod[15]}}, prod};
        end
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE cycle raises the completion token, then wait for the consumer
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = '0;
          zero_d      = 1'b1;
          illegal_d   = 1'b0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight MOPA
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      for (int r = 0; r < TILE; r++) begin
        for (int j = 0; j < TILE; j++) begin
          acc_q[r][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      a_lat_q     <= a_lat_d;
      b_lat_q     <= b_lat_d;
      acc_q       <= acc_d;
    end
  end

  // Combinational row read of the accumulator tile
  always_comb begin
    acc_rd_data = '0;
    for (int j = 0; j < TILE; j++) begin
      acc_rd_data[ACC_W*j +: ACC_W] = acc_q[acc_rd_row][j];
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALU control code produced by the decode-side ALU control.
- Performs single-cycle scalar ops with a registered result.
- Performs the multi-cycle matrix outer-product-accumulate (MOPA) into an internal 4x4 accumulator tile.
- Sits between ID/EX and EX/MEM and uses valid/ready handshakes on both sides so MOPA can stall the pipe.

Parameters:
- XLEN, 32, scalar operand/result width
- ACC_W, 32, width of each accumulator element
- TILE, 4, tile dimension (rows = cols = TILE); int8 lanes packed in XLEN

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_ctrl  in  4  operation code; ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND/NOTEQ/SGE/SGEU/JUMP/MOPA macros from define.vh; 4'b1111 = invalid
- op_a  in  XLEN  operand A (PC for JUMP; 4 packed signed int8 column vector for MOPA, lane i = bits 8i+7:8i)
- op_b  in  XLEN  operand B (4 packed signed int8 row vector for MOPA)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0, valid with out_valid
- illegal  out  1  request carried an unknown code, valid with out_valid
- acc_clr  in  1  clear all accumulators
- acc_rd_row  in  2  accumulator row select
- acc_rd_data  out  TILE*ACC_W  row acc_rd_row, element j at bits 32j+31:32j, combinational read

Behaviour:
- Reset (async, rstn=0): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, all accumulators=0, row counter=0. A reset mid-MOPA abandons the op with no partial completion.
- Ready rule: in_ready = (state==IDLE) && !acc_clr && (!out_valid || out_ready). Accept = in_valid && in_ready.

States:
- IDLE: on accept of a scalar or invalid code, register the outputs; result appears with out_valid=1 the next cycle (latency 1). On accept of MOPA, latch op_a/op_b and go to BUSY with row=0.
- BUSY: each cycle, acc[row][j] += sext(a_row) * sext(b_j) for j=0..3, then row++. When row==3, go to DONE.
- DONE: out_valid=1, result=0, zero=1, illegal=0. When out_ready=1, go to IDLE.
- MOPA timing: acceptance at edge N, rows updated at edges N+1..N+4, out_valid seen after edge N+5.

Output hold and back-to-back:
- out_valid, result, zero and illegal hold stable until out_ready=1.
- In IDLE, if out_valid && out_ready && in_valid, the new result replaces the old one in the same edge (full throughput).
- If out_ready=1 and no new accept, out_valid clears.

Scalar ops (32-bit, wrap on overflow):
- ADD a+b; SUB a-b.
- SLL/SRL/SRA shift by b[4:0].
- SLT signed, SLTU unsigned, SGE signed a>=b, SGEU unsigned a>=b, NOTEQ a!=b; each yields 0/1.
- XOR/OR/AND bitwise.
- JUMP: a+4.
- zero = (result==0).

Invalid code (4'b1111 or any unlisted):
- result=0, illegal=1, zero=1, latency 1.
- No accumulator change.

Accumulators:
- MOPA products are signed 16-bit, sign-extended to ACC_W.
- Accumulation wraps modulo 2^ACC_W with no saturation.
- acc_clr zeroes all 16 elements at the next edge. It is honoured in any state, but in_ready is low that cycle.
- acc_clr during BUSY clears the tile; the remaining rows continue accumulating from 0 and the earlier rows stay 0.
- acc_rd_data reflects register contents: updates are visible the cycle after the edge.

Test Plan:
- Reset: rstn low mid-BUSY -> out_valid=0, in_ready=1 after release, all acc_rd_data=0 for rows 0..3.
- Scalar ops: ADD 0x7FFFFFFF+1 -> 0x80000000; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SUB 5-5 -> result 0, zero=1; each with out_valid one cycle after accept.
- MOPA: op_a=0x04FF0201 (1,2,-1,4), op_b=0x0380FF02 (2,-1,-128,3), tile cleared -> row0 = {2,-1,-128,3}, row2 = {-2,1,128,-3}; a second identical MOPA doubles every element; out_valid 5 cycles after accept; in_ready=0 throughout.
- Backpressure: out_ready=0 for 3 cycles after an ADD -> result held, in_ready=0. Then out_ready=1 with in_valid XOR -> new result on the next cycle with no bubble.
- Illegal and clear: alu_ctrl=4'b1111 -> illegal=1, result 0, tile unchanged. acc_clr asserted in BUSY at row 2 -> rows 0..1 read 0, rows 2..3 contain only their own products.
